// File: rtl/seg7_rx.sv
// seg7_rx: decoder for four active-low 7-segment buses (plus decimal point).
// Each bus is double-flop synchronised and must hold for STABLE_CYCLES
// identical samples before it is decoded and latched. Patterns the encoder
// cannot produce are flagged per digit and in a sticky error flag.
//
// Optional feature macro: SEG7RX_HEX_EN
//   defined   -> patterns A..F decode to 4'hA..4'hF as valid digits
//   undefined -> BCD only; A..F patterns are treated as invalid
//
// Ports:
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   nHEX0..3   active-low segment buses, bit0=a .. bit6=g, bit7=dp
//   err_clr    synchronous clear of the sticky error flag
//   digit      decoded values {d3,d2,d1,d0}, 4 bits each
//   dp         decimal-point lit flags (1 = lit), bit i from nHEXi
//   valid      last latch decoded all four digits as valid
//   update     one-cycle pulse when latched content changes
//   err_digit  per-digit invalid flags from the most recent latch
//   err        sticky error flag
module seg7_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  nHEX0,
  input  logic [7:0]  nHEX1,
  input  logic [7:0]  nHEX2,
  input  logic [7:0]  nHEX3,
  input  logic        err_clr,
  output logic [15:0] digit,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        update,
  output logic [3:0]  err_digit,
  output logic        err
);

  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned BUS_W   = NUM_DIG * SEG_W;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned CNT_W   = 8;

  logic [BUS_W-1:0]         s1;
  logic [BUS_W-1:0]         s2;
  logic [BUS_W-1:0]         prev;
  logic [CNT_W-1:0]         cnt;
  logic                     latched_once;

  logic                     stable_c;
  logic                     latch_c;
  logic                     changed_c;
  logic [NUM_DIG*DIG_W-1:0] new_digit_c;
  logic [NUM_DIG-1:0]       new_dp_c;
  logic [NUM_DIG-1:0]       new_err_c;
  logic [4:0]               dec_c [NUM_DIG];

  // Returns {ok, value} for a 7-bit active-low segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
`ifdef SEG7RX_HEX_EN
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
`endif
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // Stability window: latch exactly once when the count reaches its last step.
  assign stable_c = (s2 == prev);
  assign latch_c  = stable_c && (cnt == CNT_W'(STABLE_CYCLES - 1));

  // Decode the synchronised sample; invalid digits keep their old value.
  always_comb begin
    new_digit_c = digit;
    new_dp_c    = '0;
    new_err_c   = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      dec_c[i]                   = decode_seg(s2[i*SEG_W +: 7]);
      new_dp_c[i]                = ~s2[i*SEG_W + 7];
      new_err_c[i]               = ~dec_c[i][4];
      if (dec_c[i][4])
        new_digit_c[i*DIG_W +: DIG_W] = dec_c[i][3:0];
    end
    changed_c = ({new_digit_c, new_dp_c, new_err_c} != {digit, dp, err_digit});
  end

  // Sync chain, stability counter and latched outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      cnt          <= '0;
      latched_once <= 1'b0;
      digit        <= '0;
      dp           <= '0;
      valid        <= 1'b0;
      update       <= 1'b0;
      err_digit    <= '0;
      err          <= 1'b0;
    end else begin
      s1     <= {nHEX3, nHEX2, nHEX1, nHEX0};
      s2     <= s1;
      prev   <= s2;
      update <= 1'b0;

      if (!stable_c)
        cnt <= '0;
      else if (cnt < CNT_W'(STABLE_CYCLES))
        cnt <= cnt + CNT_W'(1);

      if (latch_c) begin
        digit        <= new_digit_c;
        dp           <= new_dp_c;
        err_digit    <= new_err_c;
        valid        <= (new_err_c == '0);
        update       <= changed_c || !latched_once;
        latched_once <= 1'b1;
      end

      // Set wins over clear; a clear is ignored while the latched content
      // is still invalid, so the flag cannot drop under a live fault.
      if (latch_c && (new_err_c != '0))
        err <= 1'b1;
      else if (err_clr && (err_digit == '0))
        err <= 1'b0;
    end
  end

endmodule
